// File: rtl/spi_eeprom_target.sv
// spi_eeprom_target: SPI mode-0 serial-EEPROM responder backed by a 2^ADDR_W-byte image.
// Answers READ (0x03) with an auto-incrementing stream and RDSR (0x05).
// Optional feature macro: SPI_EEPROM_WRITE_EN adds WREN (0x06), WRDI (0x04) and WRITE (0x02).
// A parallel load port preloads the image while the target is deselected.
module spi_eeprom_target #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck,
    input  logic              cs_n,
    input  logic              copi,
    output logic              cipo,
    output logic              cipo_oe,
    input  logic              load_valid,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    output logic              load_ready,
    output logic              busy
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int AC_W  = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
    localparam logic [AC_W-1:0] ADDR_LAST = AC_W'(ADDR_W - 1);

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_RDSR  = 8'h05;
`ifdef SPI_EEPROM_WRITE_EN
    localparam logic [7:0] CMD_WREN  = 8'h06;
    localparam logic [7:0] CMD_WRDI  = 8'h04;
    localparam logic [7:0] CMD_WRITE = 8'h02;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_STATUS,
        ST_IGNORE
    } state_t;

    // Synchronizers; sck has a third flop for edge detection
    logic sck_meta_q, sck_sync_q, sck_prev_q;
    logic cs_meta_q, cs_sync_q;
    logic copi_meta_q, copi_sync_q;

    state_t             state_q, state_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [AC_W-1:0]    addr_cnt_q, addr_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               wel_q, wel_d;
    logic               is_write_q, is_write_d;
    logic               cipo_q, cipo_d;
    logic               wr_pend_q, wr_pend_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [7:0]         wr_data_q, wr_data_d;

    logic [7:0]         mem [DEPTH];
    logic [7:0]         rd_data_q;

    logic               sck_rise, sck_fall;
    logic [7:0]         shift_in;
    logic [7:0]         status_byte;
    logic [7:0]         out_byte;

    assign sck_rise    = sck_sync_q & ~sck_prev_q;
    assign sck_fall    = ~sck_sync_q & sck_prev_q;
    assign shift_in    = {shift_q[6:0], copi_sync_q};
    assign status_byte = {6'b0, wel_q, 1'b0};
    assign out_byte    = (state_q == ST_STATUS) ? status_byte : rd_data_q;

    assign busy       = ~cs_sync_q;
    assign load_ready = cs_sync_q;
    assign cipo_oe    = (state_q == ST_RD_DATA) || (state_q == ST_STATUS);
    assign cipo       = cipo_q & cipo_oe;

    // Bring the SPI pins into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_meta_q  <= 1'b0;
            sck_sync_q  <= 1'b0;
            sck_prev_q  <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            copi_meta_q <= 1'b0;
            copi_sync_q <= 1'b0;
        end else begin
            sck_meta_q  <= sck;
            sck_sync_q  <= sck_meta_q;
            sck_prev_q  <= sck_sync_q;
            cs_meta_q   <= cs_n;
            cs_sync_q   <= cs_meta_q;
            copi_meta_q <= copi;
            copi_sync_q <= copi_meta_q;
        end
    end

    // Protocol state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd7;
            addr_cnt_q <= ADDR_LAST;
            shift_q    <= '0;
            addr_q     <= '0;
            wel_q      <= 1'b0;
            is_write_q <= 1'b0;
            cipo_q     <= 1'b0;
            wr_pend_q  <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            addr_cnt_q <= addr_cnt_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            wel_q      <= wel_d;
            is_write_q <= is_write_d;
            cipo_q     <= cipo_d;
            wr_pend_q  <= wr_pend_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Next-state: command decode, address shift, data streaming
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        addr_cnt_d = addr_cnt_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        wel_d      = wel_q;
        is_write_d = is_write_q;
        cipo_d     = cipo_q;
        wr_pend_d  = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        if (cs_sync_q) begin
            // Deselect aborts everything, including any partial byte
            state_d    = ST_IDLE;
            bit_cnt_d  = 3'd7;
            addr_cnt_d = ADDR_LAST;
            shift_d    = '0;
            cipo_d     = 1'b0;
            is_write_d = 1'b0;
            if (is_write_q) begin
                wel_d = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_CMD;
                    bit_cnt_d = 3'd7;
                    shift_d   = '0;
                end
                ST_CMD: begin
                    if (sck_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        if (bit_cnt_q == 3'd0) begin
                            addr_cnt_d = ADDR_LAST;
                            case (shift_in)
                                CMD_READ: begin
                                    state_d    = ST_ADDR;
                                    is_write_d = 1'b0;
                                end
                                CMD_RDSR:  state_d = ST_STATUS;
`ifdef SPI_EEPROM_WRITE_EN
                                CMD_WREN: begin
                                    wel_d   = 1'b1;
                                    state_d = ST_IGNORE;
                                end
                                CMD_WRDI: begin
                                    wel_d   = 1'b0;
                                    state_d = ST_IGNORE;
                                end
                                CMD_WRITE: begin
                                    if (wel_q) begin
                                        state_d    = ST_ADDR;
                                        is_write_d = 1'b1;
                                    end else begin
                                        state_d = ST_IGNORE;
                                    end
                                end
`endif
                                default:   state_d = ST_IGNORE;
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    if (sck_rise) begin
                        addr_d     = {addr_q[ADDR_W-2:0], copi_sync_q};
                        addr_cnt_d = addr_cnt_q - 1'b1;
                        bit_cnt_d  = 3'd7;
                        if (addr_cnt_q == '0) begin
                            state_d = is_write_q ? ST_WR_DATA : ST_RD_DATA;
                        end
                    end
                end
                ST_RD_DATA, ST_STATUS: begin
                    // A new byte is taken from the memory read register (or status) on the
                    // first fall of each byte; rd_data_q has settled since the last rise.
                    if (sck_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            cipo_d  = out_byte[7];
                            shift_d = {out_byte[6:0], 1'b0};
                        end else begin
                            cipo_d  = shift_q[7];
                            shift_d = {shift_q[6:0], 1'b0};
                        end
                    end
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        if (bit_cnt_q == 3'd0 && state_q == ST_RD_DATA) begin
                            addr_d = addr_q + 1'b1;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (sck_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        if (bit_cnt_q == 3'd0) begin
                            wr_pend_d = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = shift_in;
                            addr_d    = addr_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
`ifndef SPI_EEPROM_WRITE_EN
        wel_d = 1'b0;
`endif
    end

    // Image memory: one write port shared by SPI writes and the load port, registered read.
    // The two writers never coincide because loads are only accepted while deselected.
    always_ff @(posedge clk) begin
        if (wr_pend_q) begin
            mem[wr_addr_q] <= wr_data_q;
        end else if (load_valid && load_ready) begin
            mem[load_addr] <= load_data;
        end
        rd_data_q <= mem[addr_q];
    end

endmodule

// File: tb/tb_spi_eeprom_target.sv
// tb_spi_eeprom_target: scoreboard bench for spi_eeprom_target (mode-0 SPI initiator model).
// Expectations follow SPI_EEPROM_WRITE_EN when the bench is compiled with that macro.
module tb_spi_eeprom_target;
    localparam int HALF = 6;

    logic       clk;
    logic       rst_n;
    logic       sck;
    logic       cs_n;
    logic       copi;
    logic       cipo;
    logic       cipo_oe;
    logic       load_valid;
    logic [7:0] load_addr;
    logic [7:0] load_data;
    logic       load_ready;
    logic       busy;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         gate_viol = 0;
    logic [7:0] model_mem [256];
    logic [7:0] exp_q [$];
    logic [7:0] tx_q [$];

    spi_eeprom_target #(.ADDR_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sck        (sck),
        .cs_n       (cs_n),
        .copi       (copi),
        .cipo       (cipo),
        .cipo_oe    (cipo_oe),
        .load_valid (load_valid),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_ready (load_ready),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // cipo must read 0 whenever the output is not enabled
    always @(negedge clk) begin
        if (cipo_oe !== 1'b1 && cipo !== 1'b0) gate_viol++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_busy(input logic lvl, input string tag, output int lat);
        lat = 0;
        while (busy !== lvl && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (busy !== lvl) check_val({tag, "_timeout"}, 32'(busy), 32'(lvl));
    endtask

    task automatic spi_byte(input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx, output logic oe_or, output logic oe_and);
        rx = 8'h00;
        oe_or = 1'b0;
        oe_and = 1'b1;
        for (int b = 7; b >= 8 - nbits; b--) begin
            copi = tx[b];
            wait_clk(HALF);
            rx = {rx[6:0], cipo};
            oe_or = oe_or | cipo_oe;
            oe_and = oe_and & cipo_oe;
            sck = 1'b1;
            wait_clk(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic cs_start(input string tag);
        int lat;
        cs_n = 1'b0;
        wait_busy(1'b1, tag, lat);
        check_val({tag, "_busy_lat"}, 32'((lat >= 2) && (lat <= 3)), 32'd1);
        wait_clk(2);
    endtask

    task automatic cs_end(input string tag);
        wait_clk(2);
        cs_n = 1'b1;
        copi = 1'b0;
        wait_clk(HALF);
        check_val({tag, "_desel"}, {30'd0, busy, cipo_oe}, 32'd0);
        $display("[TB] transaction %s complete", tag);
    endtask

    // Send tx_q in one frame; the last n_out bytes are read back and scored
    task automatic spi_frame(input string tag, input int n_out);
        logic [7:0] rx;
        logic       oor;
        logic       oand;
        logic       hdr_oe;
        logic [7:0] e;
        hdr_oe = 1'b0;
        cs_start(tag);
        for (int i = 0; i < tx_q.size(); i++) begin
            spi_byte(tx_q[i], 8, rx, oor, oand);
            if (i < tx_q.size() - n_out) begin
                hdr_oe = hdr_oe | oor;
            end else begin
                if (exp_q.size() == 0) begin
                    check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_val({tag, "_data"}, 32'(rx), 32'(e));
                end
                check_val({tag, "_oe"}, 32'(oand), 32'd1);
            end
        end
        check_val({tag, "_hdr_oe"}, 32'(hdr_oe), 32'd0);
        cs_end(tag);
        tx_q.delete();
    endtask

    task automatic read_frame(input string tag, input logic [7:0] addr, input int n);
        logic [7:0] a;
        a = addr;
        tx_q.delete();
        tx_q.push_back(8'h03);
        tx_q.push_back(addr);
        for (int i = 0; i < n; i++) begin
            tx_q.push_back(8'h00);
            exp_q.push_back(model_mem[a]);
            a = a + 8'd1;
        end
        spi_frame(tag, n);
    endtask

    initial begin
        logic [7:0] rx;
        logic       oor;
        logic       oand;
        logic [7:0] e;
        int         n;

        rst_n = 1'b0;
        sck = 1'b0;
        cs_n = 1'b1;
        copi = 1'b0;
        load_valid = 1'b0;
        load_addr = 8'h00;
        load_data = 8'h00;
        wait_clk(3);
        check_val("rst_cipo", 32'(cipo), 32'd0);
        check_val("rst_oe", 32'(cipo_oe), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_ready", 32'(load_ready), 32'd1);
        rst_n = 1'b1;
        wait_clk(2);

        // Preload image: mem[k] = k ^ 0x5A
        for (int k = 0; k < 256; k++) begin
            load_valid = 1'b1;
            load_addr = 8'(k);
            load_data = 8'(k) ^ 8'h5A;
            model_mem[k] = 8'(k) ^ 8'h5A;
            wait_clk(1);
        end
        load_valid = 1'b0;
        wait_clk(2);

        // Read across the top of the address space
        read_frame("rd_wrap", 8'hFE, 3);

        // Deselect in the middle of the address byte, then a clean read
        cs_start("abort");
        spi_byte(8'h03, 8, rx, oor, oand);
        spi_byte(8'hF0, 4, rx, oor, oand);
        check_val("abort_oe", 32'(oor), 32'd0);
        cs_end("abort");
        read_frame("rd_after_abort", 8'h10, 2);

        // Unknown command followed by 16 clocks stays silent
        tx_q = '{8'hAB, 8'h00, 8'h00};
        spi_frame("unknown", 0);
        read_frame("rd_after_unk", 8'h33, 1);

        // Write enable latch behaviour
        tx_q = '{8'h02, 8'h20, 8'h77};
        spi_frame("wr_nowel", 0);
        read_frame("rd_old", 8'h20, 1);
        tx_q = '{8'h06};
        spi_frame("wren", 0);
        tx_q = '{8'h05, 8'h00, 8'h00};
`ifdef SPI_EEPROM_WRITE_EN
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h02);
`else
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
`endif
        spi_frame("rdsr_wel", 2);
        tx_q = '{8'h02, 8'h20, 8'h77};
`ifdef SPI_EEPROM_WRITE_EN
        model_mem[8'h20] = 8'h77;
`endif
        spi_frame("wr_wel", 0);
        read_frame("rd_new", 8'h20, 1);
        tx_q = '{8'h05, 8'h00};
        exp_q.push_back(8'h00);
        spi_frame("rdsr_clr", 1);

        // Reset during the second data byte of a read
        cs_start("rst_mid");
        spi_byte(8'h03, 8, rx, oor, oand);
        spi_byte(8'h40, 8, rx, oor, oand);
        exp_q.push_back(model_mem[8'h40]);
        spi_byte(8'h00, 8, rx, oor, oand);
        e = exp_q.pop_front();
        check_val("rst_mid_data", 32'(rx), 32'(e));
        spi_byte(8'h00, 4, rx, oor, oand);
        wait_clk(2);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_cipo", 32'(cipo), 32'd0);
        check_val("rst_mid_oe", 32'(cipo_oe), 32'd0);
        check_val("rst_mid_busy", 32'(busy), 32'd0);
        check_val("rst_mid_ready", 32'(load_ready), 32'd1);
        wait_clk(2);
        cs_n = 1'b1;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(4);
        $display("[TB] transaction rst_mid complete");
        read_frame("rd_after_rst", 8'h40, 2);

        // Load port is held off while selected and commits right after deselect
        cs_n = 1'b0;
        wait_busy(1'b1, "lg_sel", n);
        load_valid = 1'b1;
        load_addr = 8'h50;
        load_data = 8'hC3;
        wait_clk(4);
        check_val("lg_ready_low", 32'(load_ready), 32'd0);
        load_addr = 8'h51;
        load_data = 8'h3C;
        wait_clk(2);
        cs_n = 1'b1;
        wait_busy(1'b0, "lg_desel", n);
        check_val("lg_ready_high", 32'(load_ready), 32'd1);
        wait_clk(1);
        load_valid = 1'b0;
        model_mem[8'h51] = 8'h3C;
        $display("[TB] transaction load_gate complete");
        wait_clk(4);
        read_frame("lg_rd50", 8'h50, 1);
        read_frame("lg_rd51", 8'h51, 1);

        check_val("sb_drained", 32'(exp_q.size()), 32'd0);
        check_val("cipo_gated", 32'(gate_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
